// File: rtl/arbitro_multiplicacion.sv
// rtl/arbitro_multiplicacion.sv - round-robin arbiter sharing one n-bit multiplier between two requesters
module arbitro_multiplicacion #(
   parameter int n           = 4,
   parameter int CICLOS_CALC = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   input  logic [n-1:0] req0_a,
   input  logic [n-1:0] req0_b,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [n-1:0] req1_a,
   input  logic [n-1:0] req1_b,
   output logic         req1_ready,
   output logic         resp0_valid,
   input  logic         resp0_ready,
   output logic         resp1_valid,
   input  logic         resp1_ready,
   output logic [n-1:0] c,
   output logic [3:0]   banderas
);

   typedef enum logic [1:0] {IDLE, CALC, RESP} estado_t;

   localparam int            CW      = (CICLOS_CALC > 1) ? $clog2(CICLOS_CALC) : 1;
   localparam logic [CW-1:0] CNT_FIN = CW'(CICLOS_CALC - 1);

   estado_t       estado;
   logic          prio;
   logic          dueno;
   logic [n-1:0]  op_a;
   logic [n-1:0]  op_b;
   logic [CW-1:0] cnt;
   logic [n:0]    prod;
   logic          gnt0;
   logic          gnt1;

   // prio only breaks ties; a lone requester is always granted
   always_comb begin
      gnt0 = req0_valid && (!req1_valid || !prio);
      gnt1 = req1_valid && (!req0_valid || prio);
   end

   assign req0_ready = (estado == IDLE) && gnt0;
   assign req1_ready = (estado == IDLE) && gnt1;

   // only prod[n:0] is observed, so the product is computed n+1 bits wide
   assign prod = {1'b0, op_a} * {1'b0, op_b};

   always_ff @(posedge clk) begin
      if (rst) begin
         estado      <= IDLE;
         prio        <= 1'b0;
         dueno       <= 1'b0;
         op_a        <= '0;
         op_b        <= '0;
         cnt         <= '0;
         c           <= '0;
         banderas    <= '0;
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
      end else begin
         case (estado)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  op_a   <= gnt1 ? req1_a : req0_a;
                  op_b   <= gnt1 ? req1_b : req0_b;
                  dueno  <= gnt1;
                  cnt    <= '0;
                  estado <= CALC;
               end
            end
            CALC: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_FIN) begin
                  c           <= prod[n-1:0];
                  banderas    <= {1'b0, (prod[n-1:0] == '0), 1'b0, prod[n]};
                  resp0_valid <= !dueno;
                  resp1_valid <= dueno;
                  estado      <= RESP;
               end
            end
            RESP: begin
               if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
                  prio        <= !dueno;
                  resp0_valid <= 1'b0;
                  resp1_valid <= 1'b0;
                  estado      <= IDLE;
               end
            end
            default: estado <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arbitro_multiplicacion.sv
// tb/tb_arbitro_multiplicacion.sv - scoreboard bench for arbitro_multiplicacion
module tb_arbitro_multiplicacion;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       req0_valid, req1_valid, req0_ready, req1_ready;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic       resp0_valid, resp1_valid, resp0_ready, resp1_ready;
   logic [7:0] c;
   logic [3:0] banderas;

   logic       m_req0_valid, m_req1_valid, m_req0_ready, m_req1_ready;
   logic [7:0] m_req0_a, m_req0_b, m_req1_a, m_req1_b;
   logic       m_resp0_valid, m_resp1_valid, m_resp0_ready, m_resp1_ready;
   logic [7:0] m_c;
   logic [3:0] m_banderas;

   arbitro_multiplicacion #(.n(8), .CICLOS_CALC(1)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .c(c), .banderas(banderas)
   );

   arbitro_multiplicacion #(.n(8), .CICLOS_CALC(3)) dut3 (
      .clk(clk), .rst(rst),
      .req0_valid(m_req0_valid), .req0_a(m_req0_a), .req0_b(m_req0_b), .req0_ready(m_req0_ready),
      .req1_valid(m_req1_valid), .req1_a(m_req1_a), .req1_b(m_req1_b), .req1_ready(m_req1_ready),
      .resp0_valid(m_resp0_valid), .resp0_ready(m_resp0_ready),
      .resp1_valid(m_resp1_valid), .resp1_ready(m_resp1_ready),
      .c(m_c), .banderas(m_banderas)
   );

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic       owner;
      logic [7:0] c;
      logic [3:0] f;
   } exp_t;

   exp_t sb[$];
   exp_t e_mon;

   function automatic exp_t modelo(input logic owner, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'(a) * 16'(b);
      return {owner, p[7:0], {1'b0, (p[7:0] == 8'd0), 1'b0, p[8]}};
   endfunction

   // scoreboard: push at operand acceptance, pop at response handshake
   always @(posedge clk) if (rst) sb.delete();

   always @(negedge clk) begin
      if (!rst) begin
         if (req0_valid && req0_ready) sb.push_back(modelo(1'b0, req0_a, req0_b));
         if (req1_valid && req1_ready) sb.push_back(modelo(1'b1, req1_a, req1_b));
         if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL sb_unexpected: response owner=%0d c=%0h with nothing outstanding", resp1_valid, c);
            end else begin
               e_mon = sb.pop_front();
               if ({resp1_valid, c, banderas} !== e_mon) begin
                  fails++;
                  $display("FAIL sb_result: got owner=%0d c=%0h f=%b, expected owner=%0d c=%0h f=%b",
                           resp1_valid, c, banderas, e_mon.owner, e_mon.c, e_mon.f);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
      req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
      m_req0_valid = 0; m_req1_valid = 0; m_resp0_ready = 0; m_resp1_ready = 0;
      m_req0_a = 0; m_req0_b = 0; m_req1_a = 0; m_req1_b = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      clear_inputs();
      step();
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      clear_inputs();
      step();
      step();
      #2;
      tests++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid, c, banderas} !== 16'h0) begin
         fails++;
         $display("FAIL reset_outputs: got %h, expected 0000",
                  {req0_ready, req1_ready, resp0_valid, resp1_valid, c, banderas});
      end
      tests++;
      if ({m_req0_ready, m_req1_ready, m_resp0_valid, m_resp1_valid, m_c, m_banderas} !== 16'h0) begin
         fails++;
         $display("FAIL reset_outputs3: got %h, expected 0000",
                  {m_req0_ready, m_req1_ready, m_resp0_valid, m_resp1_valid, m_c, m_banderas});
      end
      rst = 0;
   endtask

   task automatic test_basic();
      step();
      req0_valid = 1; req0_a = 3; req0_b = 5;
      #2;
      tests++;
      if (req0_ready !== 1'b1) begin fails++; $display("FAIL t1_accept: req0_ready=%b expected 1", req0_ready); end
      step();
      req0_valid = 0; req0_a = 8'hff; req0_b = 8'hff;
      #2;
      tests++;
      if (resp0_valid !== 1'b0) begin fails++; $display("FAIL t1_early: resp0_valid=%b expected 0", resp0_valid); end
      step();
      #2;
      tests++;
      if ({resp0_valid, c, banderas} !== {1'b1, 8'd15, 4'b0000}) begin
         fails++;
         $display("FAIL t1_result: valid=%b c=%0d f=%b expected 1 15 0000", resp0_valid, c, banderas);
      end
      resp0_ready = 1;
      step();
      resp0_ready = 0;
      #2;
      tests++;
      if (resp0_valid !== 1'b0) begin fails++; $display("FAIL t1_release: resp0_valid=%b expected 0", resp0_valid); end
   endtask

   task automatic test_both_valid();
      do_reset();
      req0_valid = 1; req0_a = 2; req0_b = 4;
      req1_valid = 1; req1_a = 0; req1_b = 9;
      #2;
      tests++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         fails++;
         $display("FAIL t2_grant0: ready={%b,%b} expected {1,0}", req0_ready, req1_ready);
      end
      step();
      req0_valid = 0;
      step();
      #2;
      tests++;
      if ({resp0_valid, resp1_valid, c, banderas} !== {2'b10, 8'd8, 4'b0000}) begin
         fails++;
         $display("FAIL t2_res0: v={%b,%b} c=%0d f=%b expected {1,0} 8 0000", resp0_valid, resp1_valid, c, banderas);
      end
      resp0_ready = 1;
      step();
      resp0_ready = 0;
      #2;
      tests++;
      if (req1_ready !== 1'b1) begin fails++; $display("FAIL t2_grant1: req1_ready=%b expected 1", req1_ready); end
      step();
      req1_valid = 0;
      step();
      #2;
      tests++;
      if ({resp0_valid, resp1_valid, c, banderas} !== {2'b01, 8'd0, 4'b0100}) begin
         fails++;
         $display("FAIL t2_res1: v={%b,%b} c=%0d f=%b expected {0,1} 0 0100", resp0_valid, resp1_valid, c, banderas);
      end
      resp1_ready = 1;
      step();
      resp1_ready = 0;
   endtask

   task automatic test_overflow();
      req0_valid = 1; req0_a = 16; req0_b = 16;
      step();
      req0_valid = 0;
      step();
      #2;
      tests++;
      if ({resp0_valid, c, banderas} !== {1'b1, 8'h00, 4'b0101}) begin
         fails++;
         $display("FAIL t3_overflow: valid=%b c=%0h f=%b expected 1 00 0101", resp0_valid, c, banderas);
      end
      resp0_ready = 1;
      step();
      resp0_ready = 0;
   endtask

   task automatic test_hold();
      req0_valid = 1; req0_a = 3; req0_b = 3;
      step();
      req0_valid = 0;
      req1_valid = 1; req1_a = 5; req1_b = 5;
      step();
      for (int i = 0; i < 5; i++) begin
         #2;
         tests++;
         if ({resp0_valid, req1_ready, c, banderas} !== {2'b10, 8'd9, 4'b0000}) begin
            fails++;
            $display("FAIL t4_hold: cycle %0d valid=%b req1_ready=%b c=%0d f=%b expected 1 0 9 0000",
                     i, resp0_valid, req1_ready, c, banderas);
         end
         step();
      end
      resp0_ready = 1;
      step();
      resp0_ready = 0;
      #2;
      tests++;
      if (req1_ready !== 1'b1) begin fails++; $display("FAIL t4_grant1: req1_ready=%b expected 1", req1_ready); end
      step();
      req1_valid = 0;
      step();
      resp1_ready = 1;
      step();
      resp1_ready = 0;
   endtask

   task automatic test_reset_calc();
      req0_valid = 1; req0_a = 1; req0_b = 2;
      step();
      req0_valid = 0;
      step();
      resp0_ready = 1;
      step();
      resp0_ready = 0;
      req1_valid = 1; req1_a = 6; req1_b = 7;
      step();
      req1_valid = 0;
      rst = 1;
      step();
      rst = 0;
      #2;
      tests++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid, c, banderas} !== 16'h0) begin
         fails++;
         $display("FAIL t5_flush: got %h expected 0000",
                  {req0_ready, req1_ready, resp0_valid, resp1_valid, c, banderas});
      end
      for (int i = 0; i < 4; i++) begin
         step();
         #2;
         tests++;
         if ({resp0_valid, resp1_valid} !== 2'b00) begin
            fails++;
            $display("FAIL t5_noresp: cycle %0d v={%b,%b} expected {0,0}", i, resp0_valid, resp1_valid);
         end
      end
      step();
      req0_valid = 1; req0_a = 1; req0_b = 1;
      req1_valid = 1; req1_a = 2; req1_b = 2;
      #2;
      tests++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         fails++;
         $display("FAIL t5_prio: ready={%b,%b} expected {1,0}", req0_ready, req1_ready);
      end
      resp0_ready = 1; resp1_ready = 1;
      step();
      req0_valid = 0;
      for (int i = 0; i < 4; i++) step();
      req1_valid = 0;
      for (int i = 0; i < 3; i++) step();
      resp0_ready = 0; resp1_ready = 0;
   endtask

   task automatic test_back_to_back();
      int order[$];
      req0_valid = 1; req1_valid = 1; resp0_ready = 1; resp1_ready = 1;
      for (int i = 0; i < 30; i++) begin
         req0_a = 8'($urandom); req0_b = 8'($urandom);
         req1_a = 8'($urandom); req1_b = 8'($urandom);
         #2;
         if (req0_ready) order.push_back(0);
         if (req1_ready) order.push_back(1);
         step();
      end
      req0_valid = 0; req1_valid = 0;
      step();
      step();
      resp0_ready = 0; resp1_ready = 0;
      tests++;
      if (order.size() != 10) begin
         fails++;
         $display("FAIL b2b_count: %0d grants in 30 cycles, expected 10", order.size());
      end
      foreach (order[k]) begin
         tests++;
         if (order[k] != k % 2) begin
            fails++;
            $display("FAIL b2b_order: grant %0d went to %0d, expected %0d", k, order[k], k % 2);
         end
      end
   endtask

   task automatic test_ciclos3();
      m_req0_valid = 1; m_req0_a = 7; m_req0_b = 9;
      #2;
      tests++;
      if (m_req0_ready !== 1'b1) begin fails++; $display("FAIL t6_accept: ready=%b expected 1", m_req0_ready); end
      for (int k = 1; k <= 3; k++) begin
         step();
         m_req0_valid = 0; m_req0_a = 8'h55;
         #2;
         tests++;
         if (m_resp0_valid !== 1'b0) begin
            fails++;
            $display("FAIL t6_early: T+%0d resp0_valid=%b expected 0", k, m_resp0_valid);
         end
      end
      step();
      #2;
      tests++;
      if ({m_resp0_valid, m_c, m_banderas} !== {1'b1, 8'd63, 4'b0000}) begin
         fails++;
         $display("FAIL t6_result: valid=%b c=%0d f=%b expected 1 63 0000", m_resp0_valid, m_c, m_banderas);
      end
      m_resp0_ready = 1;
      step();
      m_resp0_ready = 0;
      #2;
      tests++;
      if (m_resp0_valid !== 1'b0) begin fails++; $display("FAIL t6_release: valid=%b expected 0", m_resp0_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_both_valid();
      test_overflow();
      test_hold();
      test_reset_calc();
      test_back_to_back();
      test_ciclos3();
      step();
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL sb_drain: %0d results never returned, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
